// File: rtl/latch_if_id.sv
// IF/ID pipeline register: captures the fetch stage's next PC and instruction
// for the decode stage, with stall (hold) and flush (bubble insert) control.
module latch_if_id #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    next_pc,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    next_pc_reg,
  output logic [INSTR_WIDTH-1:0] instruction_reg,
  output logic                   valid_reg
);

  logic [PC_WIDTH-1:0]    pc_r;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic                   valid_r;

  logic [PC_WIDTH-1:0]    pc_nxt_s;
  logic [INSTR_WIDTH-1:0] instr_nxt_s;
  logic                   valid_nxt_s;

  // Next-state selection: flush beats stall, stall beats a fresh load.
  always_comb begin
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    valid_nxt_s = valid_r;
    if (flush) begin
      pc_nxt_s    = {PC_WIDTH{1'b0}};
      instr_nxt_s = NOP_INSTR;
      valid_nxt_s = 1'b0;
    end else if (stall) begin
      pc_nxt_s    = pc_r;
      instr_nxt_s = instr_r;
      valid_nxt_s = valid_r;
    end else begin
      pc_nxt_s    = next_pc;
      instr_nxt_s = instruction;
      valid_nxt_s = 1'b1;
    end
  end

  // Pipeline state; reset loads a bubble without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= {PC_WIDTH{1'b0}};
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      instr_r <= instr_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign next_pc_reg     = pc_r;
  assign instruction_reg = instr_r;
  assign valid_reg       = valid_r;

endmodule

// File: tb/tb_latch_if_id.sv
// Scoreboard bench for latch_if_id: directed vectors push expected outputs,
// a monitor process pops and compares against the registered outputs.
module tb_latch_if_id;

  localparam int          PW  = 8;
  localparam int          IW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic [PW-1:0] next_pc;
  logic [IW-1:0] instruction;
  logic [PW-1:0] next_pc_reg;
  logic [IW-1:0] instruction_reg;
  logic          valid_reg;

  latch_if_id #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .next_pc        (next_pc),
    .instruction    (instruction),
    .next_pc_reg    (next_pc_reg),
    .instruction_reg(instruction_reg),
    .valid_reg      (valid_reg)
  );

  typedef struct {
    string         name;
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
    logic          v;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: whenever the stimulus flags a sample point, compare queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (next_pc_reg !== e.pc || instruction_reg !== e.ins || valid_reg !== e.v) begin
          tests_failed++;
          $display("FAIL %s: got pc=%0h instr=%0h valid=%0b, expected pc=%0h instr=%0h valid=%0b",
                   e.name, next_pc_reg, instruction_reg, valid_reg, e.pc, e.ins, e.v);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [PW-1:0] pc,
                            input logic [IW-1:0] ins, input logic v);
    exp_t e;
    e.name = name;
    e.pc   = pc;
    e.ins  = ins;
    e.v    = v;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  // Rising edge, then settle 1 ns before any check.
  task automatic rise();
    #4 clk = 1'b1;
    #1;
  endtask

  task automatic fall();
    #4 clk = 1'b0;
    #1;
  endtask

  task automatic set_in(input logic [PW-1:0] pc, input logic [IW-1:0] ins);
    next_pc     = pc;
    instruction = ins;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(8'd5, 32'd7);
    #1 expect_out("reset_initial", 8'd0, NOP, 1'b0);
    rise(); expect_out("reset_clk_high", 8'd0, NOP, 1'b0);
    fall();
    rise(); expect_out("reset_second_edge", 8'd0, NOP, 1'b0);
    fall();

    // Basic load with a long clock-low interval first
    rst_n = 1'b1;
    set_in(8'd1, 32'd2);
    #100 expect_out("load_before_edge", 8'd0, NOP, 1'b0);
    rise(); expect_out("basic_load", 8'd1, 32'd2, 1'b1);
    fall();

    set_in(8'd2, 32'd4);
    #1 expect_out("inputs_change_clk_low", 8'd1, 32'd2, 1'b1);
    rise(); expect_out("second_load", 8'd2, 32'd4, 1'b1);
    fall();

    // Stall holds across two edges
    stall = 1'b1;
    set_in(8'd3, 32'd6);
    rise(); expect_out("stall_edge1", 8'd2, 32'd4, 1'b1);
    fall();
    rise(); expect_out("stall_edge2", 8'd2, 32'd4, 1'b1);
    fall();
    stall = 1'b0;
    rise(); expect_out("stall_release", 8'd3, 32'd6, 1'b1);
    fall();

    // Flush wins over stall
    flush = 1'b1; stall = 1'b1;
    set_in(8'd9, 32'd18);
    rise(); expect_out("flush_over_stall", 8'd0, NOP, 1'b0);
    fall();
    flush = 1'b0; stall = 1'b0;
    rise(); expect_out("load_after_flush", 8'd9, 32'd18, 1'b1);

    // Input change while clk high has no effect
    set_in(8'h55, 32'h0000_0AAA);
    #1 expect_out("inputs_change_clk_high", 8'd9, 32'd18, 1'b1);
    fall();

    // Async reset mid-cycle, no edge needed
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset_no_edge", 8'd0, NOP, 1'b0);
    rise(); expect_out("reset_blocks_load", 8'd0, NOP, 1'b0);
    fall();
    rst_n = 1'b1;
    set_in(8'd1, 32'd2);
    #1 expect_out("reset_release_no_edge", 8'd0, NOP, 1'b0);
    rise(); expect_out("load_after_reset", 8'd1, 32'd2, 1'b1);
    fall();

    // Full-width values pass through unchanged
    set_in(8'hFF, 32'hFFFF_FFFF);
    rise(); expect_out("all_ones", 8'hFF, 32'hFFFF_FFFF, 1'b1);
    fall();
    set_in(8'hA5, 32'hDEAD_BEEF);
    rise(); expect_out("pattern_load", 8'hA5, 32'hDEAD_BEEF, 1'b1);
    fall();

    // Flush without stall
    flush = 1'b1;
    rise(); expect_out("flush_no_stall", 8'd0, NOP, 1'b0);
    fall();
    // Stall keeps a bubble a bubble
    flush = 1'b0; stall = 1'b1;
    rise(); expect_out("stall_holds_bubble", 8'd0, NOP, 1'b0);
    fall();

    #2;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
